// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: player inputs and game status between input logic and the flow controller.
// GAME_PAUSE_EN adds the pause request and paused status.
interface game_flow_ctrl_if #(parameter int SCORE_W = 12, parameter int LW = 2);
  logic pulse, died, jump;
  logic [1:0] lane;
  logic playing, game_over, invuln, reset_game, jump_out;
  logic [1:0] lane_out;
  logic [SCORE_W-1:0] time_alive, high_score;
  logic [LW-1:0] lives_left;
`ifdef GAME_PAUSE_EN
  logic pause, paused;
  modport master (output pulse, died, lane, jump, pause,
                  input playing, game_over, invuln, reset_game, jump_out, lane_out,
                        time_alive, high_score, lives_left, paused);
  modport slave (input pulse, died, lane, jump, pause,
                 output playing, game_over, invuln, reset_game, jump_out, lane_out,
                        time_alive, high_score, lives_left, paused);
`else
  modport master (output pulse, died, lane, jump,
                  input playing, game_over, invuln, reset_game, jump_out, lane_out,
                        time_alive, high_score, lives_left);
  modport slave (input pulse, died, lane, jump,
                 output playing, game_over, invuln, reset_game, jump_out, lane_out,
                        time_alive, high_score, lives_left);
`endif
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game-flow FSM with lives, grace window, saturating score and session high score.
// Optional GAME_PAUSE_EN adds a PAUSED state toggled by rising edges of pause.
module game_flow_ctrl #(
  parameter int SCORE_W = 12,
  parameter int LIVES = 3,
  parameter int GRACE_PULSES = 2,
  parameter logic [1:0] LANE_IDLE = 2'd1,
  localparam int LW = $clog2(LIVES + 1),
  localparam int GW = $clog2(GRACE_PULSES + 1)
) (
  input logic clk_in,
  input logic rst_in,
  game_flow_ctrl_if.slave g
);
  typedef enum logic [2:0] {
    START, WAIT_REL1, PLAYING, GRACE, GAMEOVER, WAIT_REL2
`ifdef GAME_PAUSE_EN
    , PAUSED
`endif
  } state_e;
  state_e state_q, state_d;
  logic [SCORE_W-1:0] time_q, time_d, high_q, high_d, t_inc;
  logic [LW-1:0] lives_q, lives_d;
  logic [GW-1:0] grace_q, grace_d;
  logic [1:0] lane_q;
  logic jump_q, act_d, in_pause, pause_grace;
`ifdef GAME_PAUSE_EN
  logic pause_q, rise;
  state_e ret_q;
  assign rise = g.pause & ~pause_q;
  assign in_pause = state_q == PAUSED;
  assign pause_grace = in_pause && ret_q == GRACE;
  assign g.paused = in_pause;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pause_q <= 1'b0;
      ret_q <= START;
    end else begin
      pause_q <= g.pause;
      if (state_q != PAUSED) ret_q <= state_q;
    end
  end
`else
  assign in_pause = 1'b0;
  assign pause_grace = 1'b0;
`endif
  assign t_inc = (g.pulse && time_q != '1) ? time_q + SCORE_W'(1) : time_q;
  always_comb begin
    state_d = state_q;
    time_d = time_q;
    high_d = high_q;
    lives_d = lives_q;
    grace_d = grace_q;
    case (state_q)
      START: begin
        time_d = '0;
        lives_d = LW'(LIVES);
        state_d = g.jump ? WAIT_REL1 : START;
      end
      WAIT_REL1: state_d = g.jump ? WAIT_REL1 : PLAYING;
      PLAYING: begin
        time_d = t_inc;
        if (g.died && lives_q > LW'(1)) begin
          state_d = GRACE;
          lives_d = lives_q - LW'(1);
          grace_d = GW'(GRACE_PULSES);
        end else if (g.died) begin
          state_d = GAMEOVER;
          lives_d = '0;
          high_d = t_inc > high_q ? t_inc : high_q;
        end
      end
      GRACE: begin
        time_d = t_inc;
        grace_d = g.pulse ? grace_q - GW'(1) : grace_q;
        state_d = (g.pulse && grace_q == GW'(1)) ? PLAYING : GRACE;
      end
      GAMEOVER: state_d = g.jump ? WAIT_REL2 : GAMEOVER;
      WAIT_REL2: state_d = g.jump ? WAIT_REL2 : START;
`ifdef GAME_PAUSE_EN
      PAUSED: state_d = rise ? ret_q : PAUSED;
`endif
      default: state_d = START;
    endcase
`ifdef GAME_PAUSE_EN
    // a pause edge wins over any pulse or hit in the same cycle
    if (rise && (state_q == PLAYING || state_q == GRACE)) begin
      state_d = PAUSED;
      time_d = time_q;
      high_d = high_q;
      lives_d = lives_q;
      grace_d = grace_q;
    end
`endif
  end
  // gating follows the next state so the exit cycle already shows idle controls
  assign act_d = state_d == PLAYING || state_d == GRACE;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= START;
      time_q <= '0;
      high_q <= '0;
      lives_q <= LW'(LIVES);
      grace_q <= '0;
      lane_q <= LANE_IDLE;
      jump_q <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q <= time_d;
      high_q <= high_d;
      lives_q <= lives_d;
      grace_q <= grace_d;
      lane_q <= act_d ? g.lane : LANE_IDLE;
      jump_q <= act_d & g.jump;
    end
  end
  assign g.playing = state_q == PLAYING || state_q == GRACE || in_pause;
  assign g.game_over = state_q == GAMEOVER || state_q == WAIT_REL2;
  assign g.invuln = state_q == GRACE || pause_grace;
  assign g.reset_game = state_q == START;
  assign g.time_alive = time_q;
  assign g.high_score = high_q;
  assign g.lives_left = lives_q;
  assign g.lane_out = lane_q;
  assign g.jump_out = jump_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed game scenarios then random play, checked against a rule-level model.
module tb_game_flow_ctrl;
  localparam int LIVES = 3;
  localparam int GRACE = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  game_flow_ctrl_if #(.SCORE_W(12), .LW(2)) a ();
  game_flow_ctrl_if #(.SCORE_W(4), .LW(2)) b ();
  assign b.pulse = a.pulse;
  assign b.died = a.died;
  assign b.lane = a.lane;
  assign b.jump = a.jump;
`ifdef GAME_PAUSE_EN
  assign b.pause = a.pause;
`endif
  game_flow_ctrl #(.SCORE_W(12)) dut (.clk_in(clk), .rst_in(rst), .g(a));
  game_flow_ctrl #(.SCORE_W(4)) dut4 (.clk_in(clk), .rst_in(rst), .g(b));

  typedef enum {P_IDLE, P_REL1, P_RUN, P_INV, P_OVER, P_REL2, P_PAUSE} ph_e;
  ph_e ph, saved;
  int m_time, m_high, m_lives, m_grace, m_lane, m_jump;
  bit m_prevp, pz;

  function automatic int sat(input int x, input int w);
    return x > (1 << w) - 1 ? (1 << w) - 1 : x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit p, input bit d, input logic [1:0] l, input bit j, input bit ps);
    bit rise, act;
    if (r) begin
      ph = P_IDLE; m_time = 0; m_high = 0; m_lives = LIVES; m_grace = 0;
      m_lane = 1; m_jump = 0; m_prevp = 0;
      return;
    end
`ifdef GAME_PAUSE_EN
    rise = ps && !m_prevp;
`else
    rise = 0;
`endif
    m_prevp = ps;
    if (rise && (ph == P_RUN || ph == P_INV)) begin
      saved = ph; ph = P_PAUSE;
    end else if (ph == P_PAUSE) begin
      if (rise) ph = saved;
    end else if (ph == P_IDLE) begin
      m_time = 0; m_lives = LIVES;
      if (j) ph = P_REL1;
    end else if (ph == P_REL1) begin
      if (!j) ph = P_RUN;
    end else if (ph == P_RUN || ph == P_INV) begin
      if (p) m_time++;
      if (ph == P_INV) begin
        if (p) m_grace--;
        if (m_grace == 0) ph = P_RUN;
      end else if (d && m_lives > 1) begin
        m_lives--; m_grace = GRACE; ph = P_INV;
      end else if (d) begin
        m_lives = 0; ph = P_OVER;
        if (m_time > m_high) m_high = m_time;
      end
    end else if (ph == P_OVER) begin
      if (j) ph = P_REL2;
    end else if (!j) ph = P_IDLE;
    act = ph == P_RUN || ph == P_INV;
    m_lane = act ? int'(l) : 1;
    m_jump = int'(act && j);
  endtask

  task automatic check_all();
    chk("playing", a.playing, ph == P_RUN || ph == P_INV || ph == P_PAUSE);
    chk("game_over", a.game_over, ph == P_OVER || ph == P_REL2);
    chk("invuln", a.invuln, ph == P_INV || (ph == P_PAUSE && saved == P_INV));
    chk("reset_game", a.reset_game, ph == P_IDLE);
    chk("lives_left", a.lives_left, m_lives);
    chk("time_alive", a.time_alive, sat(m_time, 12));
    chk("high_score", a.high_score, sat(m_high, 12));
    chk("lane_out", a.lane_out, m_lane);
    chk("jump_out", a.jump_out, m_jump);
    chk("time_alive_w4", b.time_alive, sat(m_time, 4));
    chk("high_score_w4", b.high_score, sat(m_high, 4));
`ifdef GAME_PAUSE_EN
    chk("paused", a.paused, ph == P_PAUSE);
`endif
  endtask

  task automatic cyc(input bit r, input bit p, input bit d, input bit j);
    logic [1:0] l;
    l = 2'($urandom);
    @(negedge clk);
    rst = r; a.pulse = p; a.died = d; a.jump = j; a.lane = l;
`ifdef GAME_PAUSE_EN
    a.pause = pz;
`endif
    @(posedge clk);
    model(r, p, d, l, j, pz);
    #1 check_all();
  endtask

  initial begin
    a.pulse = 0; a.died = 0; a.jump = 0; a.lane = 0; pz = 0; saved = P_IDLE;
`ifdef GAME_PAUSE_EN
    a.pause = 0;
`endif
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 1);
    chk("rst_lives", a.lives_left, 3);
    chk("rst_lane", a.lane_out, 1);
    // T1
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    repeat (5) cyc(0, 1, 0, 0);
    chk("t1_time", a.time_alive, 5);
    chk("t1_playing", a.playing, 1);
    chk("t1_lives", a.lives_left, 3);
    // T2
    cyc(0, 0, 1, 0);
    chk("t2_lives", a.lives_left, 2);
    chk("t2_invuln", a.invuln, 1);
    cyc(0, 0, 1, 0);
    chk("t2_grace_hit", a.lives_left, 2);
    repeat (2) cyc(0, 1, 0, 0);
    chk("t2_invuln_end", a.invuln, 0);
    // T3: last hit coincides with a pulse
    cyc(0, 0, 1, 0);
    repeat (2) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    chk("t3_over", a.game_over, 1);
    chk("t3_time", a.time_alive, 10);
    chk("t3_high", a.high_score, 10);
    cyc(0, 1, 0, 0);
    chk("t3_hold", a.time_alive, 10);
    // T5: held buttons must park in the release states
    repeat (3) cyc(0, 0, 0, 1);
    chk("t5_rel2", a.game_over, 1);
    cyc(0, 0, 0, 0);
    chk("t5_start", a.reset_game, 1);
    repeat (3) cyc(0, 0, 0, 1);
    chk("t5_rel1", a.playing, 0);
    cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0);
    repeat (3) begin
      cyc(0, 0, 1, 0);
      repeat (2) cyc(0, 1, 0, 0);
    end
    chk("t5_high", a.high_score, 10);
    // T4
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    repeat (20) cyc(0, 1, 0, 0);
    chk("t4_sat", b.time_alive, 15);
    chk("t4_wide", a.time_alive, 20);
`ifdef GAME_PAUSE_EN
    // T6
    cyc(0, 0, 1, 0);
    pz = 1; cyc(0, 0, 0, 0);
    chk("t6_paused", a.paused, 1);
    repeat (3) cyc(0, 1, 1, 1);
    pz = 0; cyc(0, 1, 1, 0);
    chk("t6_frozen", a.time_alive, 20);
    pz = 1; cyc(0, 0, 0, 0);
    chk("t6_resume", a.invuln, 1);
    pz = 0;
`endif
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) pz = ~pz;
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
